// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and memory, with a bounded req/ready memory handshake and a sticky trap.
module mc_ctrl_fsm #(
   parameter int TIMEOUT = 16,
   parameter int CW      = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IorD,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic [1:0] PCSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       retire,
   output logic       halt,
   output logic [1:0] cause
);

   typedef enum logic [3:0] {
      S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_TRAP
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_BUS     = 2'b10;

   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt;
   logic [1:0]    cause_q, cause_nxt;
   logic          mem_wait_state;
   logic          timed_out;

   // Handshake: mem_req stays high for the whole of FETCH/MEMRD/MEMWR; an access
   // completes in the cycle where mem_req && mem_ready, and only that cycle may
   // commit IR/PC or retire a store. A completing mem_ready beats the timeout.
   assign mem_wait_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
   assign timed_out      = (wait_cnt == WAIT_LAST) && !mem_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_RST;
         wait_cnt <= '0;
         cause_q  <= 2'b00;
      end else begin
         state   <= state_nxt;
         cause_q <= cause_nxt;
         // Staying in a memory state means this cycle was a wait; any move restarts the count.
         if (mem_wait_state && (state_nxt == state)) wait_cnt <= wait_cnt + CNT_ONE;
         else                                        wait_cnt <= '0;
      end
   end

   always_comb begin
      state_nxt = state;
      cause_nxt = cause_q;
      unique case (state)
         S_RST:    state_nxt = S_FETCH;
         S_FETCH: begin
            if (mem_ready) state_nxt = S_DECODE;
            else if (timed_out) begin
               state_nxt = S_TRAP;
               cause_nxt = CAUSE_BUS;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_RTYPE:     state_nxt = S_EXEC;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_ADDI:      state_nxt = S_ADDIEX;
               OP_J:         state_nxt = S_JUMP;
               default: begin
                  state_nxt = S_TRAP;
                  cause_nxt = CAUSE_ILLEGAL;
               end
            endcase
         end
         S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD, S_MEMWR: begin
            if (mem_ready) state_nxt = (state == S_MEMRD) ? S_MEMWB : S_FETCH;
            else if (timed_out) begin
               state_nxt = S_TRAP;
               cause_nxt = CAUSE_BUS;
            end
         end
         S_EXEC:   state_nxt = S_ALUWB;
         S_ADDIEX: state_nxt = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_nxt = S_FETCH;
         S_TRAP:   state_nxt = S_TRAP;
         default:  state_nxt = S_RST;
      endcase
   end

   always_comb begin
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IorD        = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSrc       = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      retire      = 1'b0;
      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: ALUSrcB = 2'b11;
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
         end
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            retire   = 1'b1;
         end
         S_MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            retire   = mem_ready;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         S_ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            retire   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSrc       = 2'b01;
            retire      = 1'b1;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_ADDIWB: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
         end
         S_JUMP: begin
            PCWrite = 1'b1;
            PCSrc   = 2'b10;
            retire  = 1'b1;
         end
         default: ;
      endcase
   end

   assign mem_req = MemRead | MemWrite;
   assign halt    = (state == S_TRAP);
   assign cause   = cause_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: an instruction-level model expands each instruction into
// its expected per-cycle control trace, which is checked cycle by cycle.
module tb_mc_ctrl_fsm;

   localparam int TIMEOUT = 16;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum int {
      P_RST, P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
      P_EXEC, P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP, P_TRAP
   } ph_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       memto_reg;
      logic       reg_write;
      logic       retire;
      logic       halt;
      logic [1:0] cause;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b0;
   logic       mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
   logic [1:0] PCSrc, ALUSrcB, ALUOp, cause;
   logic       ALUSrcA, RegDst, MemtoReg, RegWrite, retire, halt;
   logic [CTRL_W-1:0] got;

   logic [CTRL_W-1:0] exp_q[$];
   bit                rdy_q[$];
   int                retire_q[$];
   int                vectors = 0;
   int                miscompares = 0;
   int                cyc = 0;

   mc_ctrl_fsm #(.TIMEOUT(TIMEOUT), .CW(5)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSrc(PCSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .retire(retire), .halt(halt), .cause(cause)
   );

   assign got = {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSrc,
                 ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, retire, halt, cause};

   // ---------------- clock/reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (vectors=%0d)", vectors);
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic [CTRL_W-1:0] exp_ctrl(ph_t ph, bit r, logic [1:0] cz);
      ctrl_t c;
      c = '0;
      case (ph)
         P_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = r; c.pc_write = r; end
         P_DECODE: c.alu_src_b = 2'b11;
         P_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
         P_MEMRD:  begin c.iord = 1; c.mem_read = 1; end
         P_MEMWB:  begin c.memto_reg = 1; c.reg_write = 1; c.retire = 1; end
         P_MEMWR:  begin c.iord = 1; c.mem_write = 1; c.retire = r; end
         P_EXEC:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
         P_ALUWB:  begin c.reg_dst = 1; c.reg_write = 1; c.retire = 1; end
         P_BRANCH: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_src = 2'b01; c.retire = 1; end
         P_ADDIEX: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
         P_ADDIWB: begin c.reg_write = 1; c.retire = 1; end
         P_JUMP:   begin c.pc_write = 1; c.pc_src = 2'b10; c.retire = 1; end
         P_TRAP:   begin c.halt = 1; c.cause = cz; end
         default: ;
      endcase
      c.mem_req = c.mem_read | c.mem_write;
      return c;
   endfunction

   task automatic push(input ph_t ph, input bit r, input logic [1:0] cz);
      exp_q.push_back(exp_ctrl(ph, r, cz));
      rdy_q.push_back(r);
   endtask

   // A memory step: w wait cycles, then completion; w >= TIMEOUT gives up after TIMEOUT cycles.
   task automatic add_mem(input ph_t ph, input int w, output bit to);
      int n;
      n = (w >= TIMEOUT) ? TIMEOUT : w;
      for (int i = 0; i < n; i++) push(ph, 1'b0, 2'b00);
      to = (w >= TIMEOUT);
      if (!to) push(ph, 1'b1, 2'b00);
   endtask

   task automatic build_instr(input logic [5:0] op, input int fw, input int mw,
                              input int ntrap, output bit trapped);
      bit         to;
      logic [1:0] cz;
      cz = 2'b00;
      add_mem(P_FETCH, fw, to);
      if (to) cz = 2'b10;
      else begin
         push(P_DECODE, 1'($urandom_range(0, 1)), 2'b00);
         case (op)
            OP_LW: begin
               push(P_MEMADR, 1'($urandom_range(0, 1)), 2'b00);
               add_mem(P_MEMRD, mw, to);
               if (to) cz = 2'b10;
               else push(P_MEMWB, 1'($urandom_range(0, 1)), 2'b00);
            end
            OP_SW: begin
               push(P_MEMADR, 1'($urandom_range(0, 1)), 2'b00);
               add_mem(P_MEMWR, mw, to);
               if (to) cz = 2'b10;
            end
            OP_RTYPE: begin
               push(P_EXEC, 1'($urandom_range(0, 1)), 2'b00);
               push(P_ALUWB, 1'($urandom_range(0, 1)), 2'b00);
            end
            OP_BEQ:  push(P_BRANCH, 1'($urandom_range(0, 1)), 2'b00);
            OP_ADDI: begin
               push(P_ADDIEX, 1'($urandom_range(0, 1)), 2'b00);
               push(P_ADDIWB, 1'($urandom_range(0, 1)), 2'b00);
            end
            OP_J:    push(P_JUMP, 1'($urandom_range(0, 1)), 2'b00);
            default: cz = 2'b01;
         endcase
      end
      trapped = (cz != 2'b00);
      if (trapped) for (int i = 0; i < ntrap; i++) push(P_TRAP, 1'($urandom_range(0, 1)), cz);
   endtask

   // ---------------- scoreboard / drivers ----------------
   task automatic apply_trace(input int max_cycles);
      logic [CTRL_W-1:0] e;
      ctrl_t g;
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < max_cycles) begin
         mem_ready = rdy_q.pop_front();
         e = exp_q.pop_front();
         @(negedge clk);
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL trace cyc=%0d op=%b ready=%0d got=%h exp=%h", cyc, opcode, mem_ready, got, e);
         end
         g = got;
         if (g.retire === 1'b1) retire_q.push_back(cyc);
         cyc++;
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic do_reset;
      rst = 1'b0;
      mem_ready = 1'b0;
      exp_q.delete();
      rdy_q.delete();
      #1;
      vectors++;
      if (got !== exp_ctrl(P_RST, 1'b0, 2'b00)) begin
         miscompares++;
         $display("FAIL reset_async got=%h exp=%h", got, exp_ctrl(P_RST, 1'b0, 2'b00));
      end
      @(negedge clk);
      vectors++;
      if (got !== exp_ctrl(P_RST, 1'b0, 2'b00)) begin
         miscompares++;
         $display("FAIL reset_hold got=%h exp=%h", got, exp_ctrl(P_RST, 1'b0, 2'b00));
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      cyc = 1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      #2;
      vectors++;
      if (got !== '0) begin
         miscompares++;
         $display("FAIL reset_state got=%h exp=0", got);
      end
      do_reset();
      mem_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (got !== exp_ctrl(P_FETCH, 1'b0, 2'b00)) begin
         miscompares++;
         $display("FAIL first_fetch got=%h exp=%h", got, exp_ctrl(P_FETCH, 1'b0, 2'b00));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_stream;
      logic [5:0] ops[6];
      int         exp_ret[6];
      bit         tr;
      ops = '{OP_LW, OP_RTYPE, OP_SW, OP_ADDI, OP_BEQ, OP_J};
      exp_ret = '{5, 9, 13, 17, 20, 23};
      do_reset();
      retire_q.delete();
      foreach (ops[i]) begin
         opcode = ops[i];
         build_instr(ops[i], 0, 0, 0, tr);
         apply_trace(100);
      end
      vectors++;
      if (retire_q.size() != 6) begin
         miscompares++;
         $display("FAIL stream_retire_count got=%0d exp=6", retire_q.size());
      end
      foreach (exp_ret[i]) begin
         if (i < retire_q.size()) begin
            vectors++;
            if (retire_q[i] != exp_ret[i]) begin
               miscompares++;
               $display("FAIL stream_retire_cycle idx=%0d got=%0d exp=%0d", i, retire_q[i], exp_ret[i]);
            end
         end
      end
   endtask

   task automatic test_fetch_wait;
      bit tr;
      int start;
      do_reset();
      opcode = OP_LW;
      start = cyc;
      build_instr(OP_LW, 3, 0, 0, tr);
      apply_trace(100);
      vectors++;
      if (cyc - start != 8) begin
         miscompares++;
         $display("FAIL fetch_wait_lw_cycles got=%0d exp=8", cyc - start);
      end
   endtask

   task automatic test_illegal;
      bit tr;
      do_reset();
      opcode = 6'b111111;
      build_instr(6'b111111, 0, 0, 20, tr);
      apply_trace(100);
      vectors++;
      if (halt !== 1'b1 || cause !== 2'b01) begin
         miscompares++;
         $display("FAIL illegal_halt got=%b/%b exp=1/01", halt, cause);
      end
      do_reset();
      opcode = OP_J;
      build_instr(OP_J, 0, 0, 0, tr);
      apply_trace(100);
   endtask

   task automatic test_rd_timeout;
      bit tr;
      do_reset();
      opcode = OP_LW;
      build_instr(OP_LW, 0, TIMEOUT, 6, tr);
      apply_trace(100);
      vectors++;
      if (halt !== 1'b1 || cause !== 2'b10) begin
         miscompares++;
         $display("FAIL rd_timeout_halt got=%b/%b exp=1/10", halt, cause);
      end
   endtask

   task automatic test_wr_boundary;
      bit tr;
      do_reset();
      opcode = OP_SW;
      build_instr(OP_SW, 0, TIMEOUT - 1, 0, tr);
      apply_trace(100);
      opcode = OP_BEQ;
      build_instr(OP_BEQ, 0, 0, 0, tr);
      apply_trace(100);
      vectors++;
      if (halt !== 1'b0) begin
         miscompares++;
         $display("FAIL wr_boundary_no_trap got=%b exp=0", halt);
      end
   endtask

   task automatic test_reset_mid;
      bit tr;
      do_reset();
      opcode = OP_SW;
      build_instr(OP_SW, 0, 10, 0, tr);
      apply_trace(6);
      mem_ready = 1'b0;
      #1;
      vectors++;
      if (mem_req !== 1'b1 || MemWrite !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_wr_active got=%b/%b exp=1/1", mem_req, MemWrite);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (mem_req !== 1'b0 || MemWrite !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_wr_async_drop got=%b/%b exp=0/0", mem_req, MemWrite);
      end
      do_reset();
      opcode = OP_ADDI;
      build_instr(OP_ADDI, 0, 0, 0, tr);
      apply_trace(100);
   endtask

   task automatic test_random;
      logic [5:0] legal[6];
      logic [5:0] op;
      int         fw, mw;
      bit         tr;
      legal = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
      do_reset();
      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
         else op = legal[$urandom_range(0, 5)];
         fw = ($urandom_range(0, 19) == 0) ? TIMEOUT + 2 : $urandom_range(0, 3);
         mw = ($urandom_range(0, 11) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1) : $urandom_range(0, 4);
         opcode = op;
         build_instr(op, fw, mw, 3, tr);
         apply_trace(200);
         if (tr) do_reset();
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_fetch_wait();
      test_illegal();
      test_rd_timeout();
      test_wr_boundary();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
